// File: rtl/gate_resp_checker.sv
// Checks (pattern, observed output) pairs against a truth table, counts mismatches and tracks coverage.
// Latency: results and DONE are visible the cycle after the handshake.
// Backpressure: in_ready is high only while a run is active; pairs offered at other times are ignored.
module gate_resp_checker #(
    parameter int                      N_IN  = 2,
    parameter logic [(1<<N_IN)-1:0]    TRUTH = 4'b0110,
    parameter int                      ERR_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   in_valid,
    input  logic [N_IN-1:0]        in_pattern,
    input  logic                   in_obs,
    output logic                   in_ready,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [ERR_W-1:0]       err_count,
    output logic                   first_fail_valid,
    output logic [N_IN-1:0]        first_fail_pat,
    output logic [(1<<N_IN)-1:0]   seen_mask
);
    localparam int NP = 1 << N_IN;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic             hs;
    logic             mismatch;
    logic             clear;
    logic             enter_done;
    logic [ERR_W-1:0] err_d;
    logic [NP-1:0]    seen_d;

    assign in_ready = (state_q == RUN);
    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);

    // abort drops any pair offered in the same cycle
    assign hs       = in_valid & in_ready & ~abort;
    assign mismatch = (in_obs != TRUTH[in_pattern]);
    assign err_d    = (mismatch && !(&err_count)) ? err_count + 1'b1 : err_count;
    assign seen_d   = seen_mask | (NP'(1) << in_pattern);
    assign clear    = start & ~abort & (state_q != RUN);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (clear) state_d = RUN;
            RUN: begin
                if (abort)                   state_d = IDLE;
                else if (hs && (&seen_d))    state_d = DONE;
            end
            DONE: begin
                if (abort)      state_d = IDLE;
                else if (start) state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    assign enter_done = (state_q == RUN) && (state_d == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            err_count        <= '0;
            seen_mask        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_pat   <= '0;
            pass             <= 1'b0;
        end else begin
            state_q <= state_d;
            if (clear) begin
                err_count        <= '0;
                seen_mask        <= '0;
                first_fail_valid <= 1'b0;
                first_fail_pat   <= '0;
                pass             <= 1'b0;
            end else if (hs) begin
                err_count <= err_d;
                seen_mask <= seen_d;
                if (mismatch && !first_fail_valid) begin
                    first_fail_valid <= 1'b1;
                    first_fail_pat   <= in_pattern;
                end
            end
            // pass reflects the count including the final pair
            if (enter_done) pass <= (err_d == '0);
        end
    end
endmodule

// File: tb/tb_gate_resp_checker.sv
// Scoreboard bench for gate_resp_checker: XOR truth table, plus an ERR_W=2 copy for saturation.
module tb_gate_resp_checker;
    logic       clk, rst_n, start, abort, in_valid, in_obs;
    logic [1:0] in_pattern;

    logic       a_in_ready, a_busy, a_done, a_pass, a_ffv;
    logic [7:0] a_err;
    logic [1:0] a_ffp;
    logic [3:0] a_seen;
    logic       b_in_ready, b_busy, b_done, b_pass, b_ffv;
    logic [1:0] b_err;
    logic [1:0] b_ffp;
    logic [3:0] b_seen;

    gate_resp_checker #(.N_IN(2), .TRUTH(4'b0110), .ERR_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .in_valid(in_valid), .in_pattern(in_pattern), .in_obs(in_obs),
        .in_ready(a_in_ready), .busy(a_busy), .done(a_done), .pass(a_pass),
        .err_count(a_err), .first_fail_valid(a_ffv), .first_fail_pat(a_ffp),
        .seen_mask(a_seen)
    );

    gate_resp_checker #(.N_IN(2), .TRUTH(4'b0110), .ERR_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .in_valid(in_valid), .in_pattern(in_pattern), .in_obs(in_obs),
        .in_ready(b_in_ready), .busy(b_busy), .done(b_done), .pass(b_pass),
        .err_count(b_err), .first_fail_valid(b_ffv), .first_fail_pat(b_ffp),
        .seen_mask(b_seen)
    );

    typedef struct packed {
        logic [7:0] err;
        logic [3:0] seen;
        logic       ffv;
        logic [1:0] ffp;
        logic       done;
        logic       busy;
    } snap_t;

    snap_t      sb_q[$];
    int         n_pass  = 0;
    int         n_total = 0;
    logic [3:0] truth_tb = 4'b0110;
    logic [7:0] m_err;
    logic [3:0] m_seen;
    logic       m_ffv;
    logic [1:0] m_ffp;
    logic       hs_q;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: act=running req=finished");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: act=%0h req=%0h", name, act, req);
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic model_clear();
        m_err = '0; m_seen = '0; m_ffv = 1'b0; m_ffp = '0;
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
        model_clear();
    endtask

    task automatic send(input logic [1:0] p, input logic o);
        logic  mm;
        snap_t s;
        in_valid = 1'b1; in_pattern = p; in_obs = o;
        mm = (o != truth_tb[p]);
        if (mm && m_err != 8'hFF) m_err = m_err + 8'd1;
        if (mm && !m_ffv) begin m_ffv = 1'b1; m_ffp = p; end
        m_seen[p] = 1'b1;
        s.err = m_err; s.seen = m_seen; s.ffv = m_ffv; s.ffp = m_ffp;
        s.done = &m_seen; s.busy = ~(&m_seen);
        sb_q.push_back(s);
        cyc();
        in_valid = 1'b0;
    endtask

    // handshake seen at an edge; its result is compared at the following falling edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hs_q <= 1'b0;
        else        hs_q <= in_valid & a_in_ready & ~abort;
    end

    initial begin
        snap_t e;
        forever begin
            @(negedge clk);
            if (hs_q) begin
                if (sb_q.size() == 0) chk("sb_unexpected_handshake", 32'd1, 32'd0);
                else begin
                    e = sb_q.pop_front();
                    chk("sb_result", {15'd0, a_err, a_seen, a_ffv, a_ffp, a_done, a_busy}, {15'd0, e});
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        in_valid = 1'b0; in_pattern = '0; in_obs = 1'b0;
        model_clear();
        #3;
        chk("reset_outputs_a", {a_in_ready, a_busy, a_done, a_pass, a_err, a_ffv, a_ffp, a_seen}, 32'd0);
        #10 rst_n = 1'b1;
        cyc();

        // 1: XOR-correct responses
        do_start();
        chk("t1_busy_after_start", {a_busy, a_in_ready, a_done}, 32'b110);
        send(2'd0, 1'b0); send(2'd1, 1'b1); send(2'd2, 1'b1); send(2'd3, 1'b0);
        chk("t1_pass", a_pass, 32'd1);
        chk("t1_final", {a_done, a_busy, a_in_ready, a_err, a_seen, a_ffv}, {3'b100, 8'd0, 4'b1111, 1'b0});

        // 2: AND-gate responses, restart straight from DONE
        do_start();
        chk("t2_cleared", {a_busy, a_err, a_seen, a_ffv, a_pass}, {1'b1, 8'd0, 4'd0, 1'b0, 1'b0});
        send(2'd0, 1'b0); send(2'd1, 1'b0); send(2'd2, 1'b0); send(2'd3, 1'b1);
        chk("t2_err", a_err, 32'd3);
        chk("t2_pass", a_pass, 32'd0);
        chk("t2_first_fail", {a_ffv, a_ffp}, {1'b1, 2'b01});
        chk("t2_done", a_done, 32'd1);

        // 3: duplicate pattern does not advance coverage
        do_start();
        send(2'd0, 1'b0); send(2'd0, 1'b0); send(2'd1, 1'b1); send(2'd2, 1'b1);
        cyc();
        chk("t3_still_busy", {a_busy, a_done, a_seen}, {1'b1, 1'b0, 4'b0111});
        send(2'd3, 1'b0);
        chk("t3_done", {a_done, a_pass}, 32'b11);

        // 4: repeated mismatches; narrow counter saturates
        do_start();
        for (int i = 0; i < 5; i++) send(2'd1, 1'b0);
        send(2'd0, 1'b0); send(2'd2, 1'b1); send(2'd3, 1'b0);
        chk("t4_err_sat", b_err, 32'd3);
        chk("t4_pass_b", {b_done, b_pass}, 32'b10);
        chk("t4_err_wide", a_err, 32'd5);

        // 5: input ignored in IDLE, abort holds results, start clears
        rst_n = 1'b0; model_clear();
        cyc();
        rst_n = 1'b1;
        cyc();
        in_valid = 1'b1; in_pattern = 2'd2; in_obs = 1'b1;
        cyc(); cyc();
        chk("t5_idle_not_ready", a_in_ready, 32'd0);
        chk("t5_idle_seen", a_seen, 32'd0);
        in_valid = 1'b0;
        do_start();
        send(2'd0, 1'b1); send(2'd1, 1'b1);
        abort = 1'b1; in_valid = 1'b1; in_pattern = 2'd3; in_obs = 1'b1;
        cyc();
        abort = 1'b0; in_valid = 1'b0;
        chk("t5_abort_state", {a_busy, a_done, a_in_ready}, 32'd0);
        chk("t5_abort_held", {a_err, a_seen, a_ffv, a_ffp}, {8'd1, 4'b0011, 1'b1, 2'b00});
        do_start();
        chk("t5_restart_clear", {a_busy, a_err, a_seen, a_ffv}, {1'b1, 8'd0, 4'd0, 1'b0});

        // 6: asynchronous reset mid-run
        send(2'd0, 1'b0); send(2'd3, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_reset_a", {a_in_ready, a_busy, a_done, a_pass, a_err, a_ffv, a_ffp, a_seen}, 32'd0);
        chk("t6_reset_b", {b_in_ready, b_busy, b_done, b_pass, b_err, b_ffv, b_ffp, b_seen}, 32'd0);
        model_clear();
        cyc();
        rst_n = 1'b1;
        cyc();

        // start and abort together: abort wins
        start = 1'b1; abort = 1'b1;
        cyc();
        start = 1'b0; abort = 1'b0;
        chk("start_abort_idle", a_busy, 32'd0);
        do_start();
        chk("start_alone_run", a_busy, 32'd1);

        cyc();
        chk("sb_drained", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
